dht11_sampler: RTL

Periodic acquisition controller that sits between the DHT11 bus driver (`dht11`) and the display/reporting logic. It clears and triggers the driver on a fixed period and supervises each transaction with a timeout. Accepted samples are range-checked, converted to two-digit BCD and published with a one-cycle valid strobe. Consecutive failures are counted and flagged as a fault.

---
 rtl/dht11_sampler.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht11_sampler.sv
// Periodic DHT11 acquisition controller: clears and triggers the bus driver on a fixed
// period, supervises each transaction, range-checks and BCD-converts accepted samples.
module dht11_sampler #(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  localparam int unsigned FC_W = $clog2(MAX_RETRIES + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  output logic            dht_reset,
  output logic            dht_start,
  input  logic            dht_pronto,
  input  logic            dht_error,
  input  logic [15:0]     dht_temperatura,
  input  logic [15:0]     dht_umidade,
  output logic [7:0]      temp_int,
  output logic [7:0]      umid_int,
  output logic [7:0]      temp_bcd,
  output logic [7:0]      umid_bcd,
  output logic            sample_valid,
  output logic            data_ok,
  output logic            fault,
  output logic [FC_W-1:0] fail_count
);

  localparam int unsigned PER_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // HOLDOFF ends two cycles before the next START so CLEAR fits in between.
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_RETRIES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_CONVERT = 3'd5;
  localparam logic [2:0] S_PUBLISH = 3'd6;
  localparam logic [2:0] S_HOLDOFF = 3'd7;

  function automatic logic [FC_W-1:0] fail_sat_inc(input logic [FC_W-1:0] fc);
    return (fc >= FC_MAX) ? FC_MAX : fc + FC_W'(1);
  endfunction

  function automatic logic in_range(input logic [7:0] t, input logic [7:0] h);
    return (h >= 8'd1) && (h <= 8'd99) && (t <= 8'd60);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [FC_W-1:0]  fail_q, fail_d, fc_inc;
  logic             fault_q, fault_d;
  logic             data_ok_q, data_ok_d;
  logic [7:0]       temp_int_q, temp_int_d, umid_int_q, umid_int_d;
  logic [7:0]       temp_bcd_q, temp_bcd_d, umid_bcd_q, umid_bcd_d;
  logic             dht_reset_q, dht_start_q, sample_valid_q;
  logic [7:0]       t_raw_q, t_raw_d, h_raw_q, h_raw_d;
  logic [7:0]       t_rem_q, t_rem_d, h_rem_q, h_rem_d;
  logic [3:0]       t_tens_q, t_tens_d, h_tens_q, h_tens_d;
  logic             fail_now;
  logic             unused_lo;

  assign unused_lo = ^{dht_temperatura[7:0], dht_umidade[7:0]};
  assign fc_inc    = fail_sat_inc(fail_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    per_d      = per_q;
    fail_d     = fail_q;
    fault_d    = fault_q;
    data_ok_d  = data_ok_q;
    temp_int_d = temp_int_q;
    umid_int_d = umid_int_q;
    temp_bcd_d = temp_bcd_q;
    umid_bcd_d = umid_bcd_q;
    t_raw_d    = t_raw_q;
    h_raw_d    = h_raw_q;
    t_rem_d    = t_rem_q;
    h_rem_d    = h_rem_q;
    t_tens_d   = t_tens_q;
    h_tens_d   = h_tens_q;
    fail_now   = 1'b0;

    // Period counter measures cycles since the last START, independent of outcome.
    if (state_q == S_START) begin
      per_d = PER_W'(1);
    end else if (per_q < PER_LAST) begin
      per_d = per_q + PER_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_START;
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMO_W'(1);
        if (dht_error) begin
          fail_now = 1'b1;
        end else if (dht_pronto) begin
          t_raw_d = dht_temperatura[15:8];
          h_raw_d = dht_umidade[15:8];
          state_d = S_CHECK;
        end else if (timer_q == TMO_LAST) begin
          fail_now = 1'b1;
        end
      end
      S_CHECK: begin
        if (in_range(t_raw_q, h_raw_q)) begin
          t_rem_d  = t_raw_q;
          h_rem_d  = h_raw_q;
          t_tens_d = '0;
          h_tens_d = '0;
          state_d  = S_CONVERT;
        end else begin
          fail_now = 1'b1;
        end
      end
      S_CONVERT: begin
        // Repeated subtraction: both values step in parallel until each is a single digit.
        if ((t_rem_q < 8'd10) && (h_rem_q < 8'd10)) begin
          temp_int_d = t_raw_q;
          umid_int_d = h_raw_q;
          temp_bcd_d = {t_tens_q, t_rem_q[3:0]};
          umid_bcd_d = {h_tens_q, h_rem_q[3:0]};
          data_ok_d  = 1'b1;
          fail_d     = '0;
          fault_d    = 1'b0;
          state_d    = S_PUBLISH;
        end else begin
          if (t_rem_q >= 8'd10) begin
            t_rem_d  = t_rem_q - 8'd10;
            t_tens_d = t_tens_q + 4'd1;
          end
          if (h_rem_q >= 8'd10) begin
            h_rem_d  = h_rem_q - 8'd10;
            h_tens_d = h_tens_q + 4'd1;
          end
        end
      end
      S_PUBLISH: begin
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (per_q >= PER_LAST) state_d = enable ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fail_now) begin
      fail_d  = fc_inc;
      fault_d = (fc_inc >= FC_MAX);
      state_d = S_HOLDOFF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      per_q          <= '0;
      fail_q         <= '0;
      fault_q        <= 1'b0;
      data_ok_q      <= 1'b0;
      temp_int_q     <= '0;
      umid_int_q     <= '0;
      temp_bcd_q     <= '0;
      umid_bcd_q     <= '0;
      dht_reset_q    <= 1'b0;
      dht_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      per_q          <= per_d;
      fail_q         <= fail_d;
      fault_q        <= fault_d;
      data_ok_q      <= data_ok_d;
      temp_int_q     <= temp_int_d;
      umid_int_q     <= umid_int_d;
      temp_bcd_q     <= temp_bcd_d;
      umid_bcd_q     <= umid_bcd_d;
      dht_reset_q    <= (state_d == S_CLEAR);
      dht_start_q    <= (state_d == S_START);
      sample_valid_q <= (state_d == S_PUBLISH);
    end
  end

  // Conversion scratch registers are fully reloaded before use, so they carry no reset.
  always_ff @(posedge clock) begin
    t_raw_q  <= t_raw_d;
    h_raw_q  <= h_raw_d;
    t_rem_q  <= t_rem_d;
    h_rem_q  <= h_rem_d;
    t_tens_q <= t_tens_d;
    h_tens_q <= h_tens_d;
  end

  assign dht_reset    = dht_reset_q;
  assign dht_start    = dht_start_q;
  assign sample_valid = sample_valid_q;
  assign data_ok      = data_ok_q;
  assign fault        = fault_q;
  assign fail_count   = fail_q;
  assign temp_int     = temp_int_q;
  assign umid_int     = umid_int_q;
  assign temp_bcd     = temp_bcd_q;
  assign umid_bcd     = umid_bcd_q;

endmodule
